// File: rtl/sram_slave_ctrl.sv
// Avalon-style memory slave that runs each accepted request as a timed cycle
// on a 1M x 16 asynchronous SRAM; all SRAM pins come straight from flops.
module sram_slave_ctrl #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdataready,
    output logic                      waitrequest,
    output logic [ADDR_WIDTH-1:0]     sram_address,
    inout  logic [DATA_WIDTH-1:0]     sram_data,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic [DATA_WIDTH/8-1:0]   sram_be_n
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned WAIT_MAX  = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned CNT_WIDTH = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BE_WIDTH-1:0]    be_n_q, be_n_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   drive_q, drive_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_n_q  <= '1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_n_q  <= be_n_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic computes the pin values for the following cycle, so
    // every strobe change lands on a clock edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_n_d  = be_n_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        drive_d = drive_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (read) begin
                    addr_d  = address;
                    be_n_d  = ~byteenable;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    we_n_d  = 1'b1;
                    cnt_d   = CNT_WIDTH'(READ_WAIT);
                    state_d = RD_WAIT;
                end else if (write) begin
                    addr_d  = address;
                    be_n_d  = ~byteenable;
                    wdata_d = writedata;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    drive_d = 1'b1;
                    state_d = WR_SETUP;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = sram_data;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = '1;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CNT_WIDTH'(WRITE_WAIT);
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            WR_HOLD: begin
                ce_n_d  = 1'b1;
                be_n_d  = '1;
                drive_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign waitrequest   = !((state_q == RD_DONE) || (state_q == WR_HOLD));
    assign readdataready = (state_q == RD_DONE);
    assign readdata      = rdata_q;
    assign sram_address  = addr_q;
    assign sram_be_n     = be_n_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_data     = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_slave_ctrl.sv
// Bench for sram_slave_ctrl: two instances (READ_WAIT=1 and 3) on separate
// behavioural SRAMs, table vectors, corner sequences and random traffic.
module tb_sram_slave_ctrl;

    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_RW = 2;
    localparam int WW    = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [19:0] address;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        read0, write0, read1, write1;

    logic [15:0] readdata0, readdata1;
    logic        rdy0, rdy1, wait0, wait1;
    logic [19:0] sa0, sa1;
    logic        ce0, oe0, we0, ce1, oe1, we1;
    logic [1:0]  be0, be1;
    tri1  [15:0] bus0;
    tri1  [15:0] bus1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram_mem [0:1023];
    logic [15:0] ref_mem  [0:1023];

    always #5 clock = ~clock;

    sram_slave_ctrl dut0 (
        .clock(clock), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .read(read0), .write(write0), .writedata(writedata), .readdata(readdata0),
        .readdataready(rdy0), .waitrequest(wait0), .sram_address(sa0), .sram_data(bus0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0), .sram_be_n(be0)
    );

    sram_slave_ctrl #(.READ_WAIT(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .read(read1), .write(write1), .writedata(writedata), .readdata(readdata1),
        .readdataready(rdy1), .waitrequest(wait1), .sram_address(sa1), .sram_data(bus1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1), .sram_be_n(be1)
    );

    // Asynchronous SRAM: outputs while CE/OE low, stores enabled lanes while WE low.
    assign bus0 = (!ce0 && !oe0 && we0) ? sram_mem[sa0[9:0]] : 'z;
    assign bus1 = (!ce1 && !oe1 && we1) ? sram_mem[sa1[9:0]] : 'z;

    always @(negedge clock) begin
        for (int b = 0; b < 2; b++) begin
            if (!ce0 && !we0 && !be0[b]) sram_mem[sa0[9:0]][b*8 +: 8] <= bus0[b*8 +: 8];
            if (!ce1 && !we1 && !be1[b]) sram_mem[sa1[9:0]][b*8 +: 8] <= bus1[b*8 +: 8];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Runs one request starting in the current cycle (T0) and records per-cycle
    // observations as bitmasks indexed by cycle number relative to T0.
    task automatic do_txn(input int dut, input int op, input logic [19:0] addr,
                          input logic [1:0] be, input logic [15:0] wd, input int drop_at,
                          output logic [15:0] rdata, output int ack, output int wl_cnt,
                          output logic [31:0] rdy_m, output logic [31:0] oe_m,
                          output logic [31:0] we_m, output logic [31:0] drv_m);
        logic w, r, o, e;
        logic [15:0] bus, rd;
        address    = addr;
        byteenable = be;
        writedata  = wd;
        read0  = (dut == 0) && (op != OP_WR);
        write0 = (dut == 0) && (op != OP_RD);
        read1  = (dut == 1) && (op != OP_WR);
        write1 = (dut == 1) && (op != OP_RD);
        ack = -1; wl_cnt = 0; rdata = '0;
        rdy_m = '0; oe_m = '0; we_m = '0; drv_m = '0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            if (dut == 1) begin
                w = wait1; r = rdy1; o = oe1; e = we1; bus = bus1; rd = readdata1;
            end else begin
                w = wait0; r = rdy0; o = oe0; e = we0; bus = bus0; rd = readdata0;
            end
            if (!w) begin
                wl_cnt++;
                if (ack < 0) ack = k;
            end
            if (r) begin
                rdy_m[k] = 1'b1;
                rdata    = rd;
            end
            if (!o) oe_m[k] = 1'b1;
            if (!e) we_m[k] = 1'b1;
            if (o && bus != 16'hFFFF) drv_m[k] = 1'b1;
            @(posedge clock);
            #1;
            if (k == drop_at || k == ack) begin
                read0 = 0; write0 = 0; read1 = 0; write1 = 0;
            end
            if (ack >= 0 && k == ack + 1) break;
        end
        read0 = 0; write0 = 0; read1 = 0; write1 = 0;
    endtask

    // Expected timing derived from the wait-state counts: reads acknowledge at
    // READ_WAIT+2, writes at WRITE_WAIT+3, with the strobe windows in between.
    task automatic check_txn(input string tag, input int dut, input int op,
                             input logic [15:0] exp_rd, input logic [15:0] rdata,
                             input int ack, input int wl_cnt, input logic [31:0] rdy_m,
                             input logic [31:0] oe_m, input logic [31:0] we_m,
                             input logic [31:0] drv_m);
        int rw;
        int exp_ack;
        rw = (dut == 1) ? 3 : 1;
        if (ack < 0) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        exp_ack = (op == OP_WR) ? WW + 3 : rw + 2;
        check({tag, "_ack"}, ack, exp_ack);
        check({tag, "_waitlow_count"}, wl_cnt, 1);
        if (op == OP_WR) begin
            check({tag, "_we_window"}, we_m, ((32'd1 << (WW + 1)) - 1) << 2);
            check({tag, "_oe_window"}, oe_m, 0);
            check({tag, "_bus_drive"}, drv_m, ((32'd1 << (WW + 3)) - 1) << 1);
            check({tag, "_rdy"}, rdy_m, 0);
        end else begin
            check({tag, "_oe_window"}, oe_m, ((32'd1 << (rw + 1)) - 1) << 1);
            check({tag, "_we_window"}, we_m, 0);
            check({tag, "_bus_drive"}, drv_m, 0);
            check({tag, "_rdy"}, rdy_m, 32'd1 << exp_ack);
            check({tag, "_rdata"}, rdata, exp_rd);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] m;
        m = old;
        if (be[0]) m[7:0]  = wd[7:0];
        if (be[1]) m[15:8] = wd[15:8];
        return m;
    endfunction

    typedef struct {
        int          dut;
        int          op;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0] rdata;
        int          ack, wl_cnt;
        logic [31:0] rdy_m, oe_m, we_m, drv_m;
        int          op, dut;
        logic [19:0] a;
        logic [1:0]  be;
        logic [15:0] wd;

        vecs[0]  = '{0, OP_WR, 20'h0005A, 2'b11, 16'hBEEF, 16'h0000};
        vecs[1]  = '{0, OP_RD, 20'h0005A, 2'b11, 16'h0000, 16'hBEEF};
        vecs[2]  = '{0, OP_WR, 20'h0005A, 2'b01, 16'h1234, 16'h0000};
        vecs[3]  = '{0, OP_RD, 20'h0005A, 2'b11, 16'h0000, 16'hBE34};
        vecs[4]  = '{1, OP_RD, 20'h0005A, 2'b11, 16'h0000, 16'hBE34};
        vecs[5]  = '{0, OP_RW, 20'h00010, 2'b11, 16'h0000, 16'hA5A5};
        vecs[6]  = '{0, OP_RD, 20'h00010, 2'b11, 16'h0000, 16'hA5A5};
        vecs[7]  = '{0, OP_WR, 20'h00020, 2'b11, 16'h1111, 16'h0000};
        vecs[8]  = '{0, OP_WR, 20'h00020, 2'b00, 16'h7777, 16'h0000};
        vecs[9]  = '{0, OP_RD, 20'h00020, 2'b11, 16'h0000, 16'h1111};
        vecs[10] = '{1, OP_WR, 20'h00020, 2'b10, 16'hABCD, 16'h0000};
        vecs[11] = '{1, OP_RD, 20'h00020, 2'b11, 16'h0000, 16'hAB11};

        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 16'(i * 16'h0101 + 16'h0F0F);
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[16] = 16'hA5A5;
        ref_mem[16]  = 16'hA5A5;

        reset_n = 1'b0;
        address = '0; byteenable = '0; writedata = 16'h5A5A;
        read0 = 0; write0 = 0; read1 = 0; write1 = 0;
        repeat (3) @(negedge clock);
        check("rst_waitrequest", wait0, 1);
        check("rst_readdataready", rdy0, 0);
        check("rst_strobes", {ce0, oe0, we0}, 3'b111);
        check("rst_be_n", be0, 2'b11);
        check("rst_bus_z", bus0, 16'hFFFF);
        check("rst_address", sa0, 0);
        check("rst_readdata", readdata0, 0);
        check("rst_dut1_waitrequest", wait1, 1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].dut, vecs[i].op, vecs[i].addr, vecs[i].be, vecs[i].wdata, -1,
                   rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);
            check_txn($sformatf("vec%0d", i), vecs[i].dut, vecs[i].op, vecs[i].exp_rdata,
                      rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);
            if (vecs[i].op == OP_WR)
                ref_mem[vecs[i].addr[9:0]] = merge(ref_mem[vecs[i].addr[9:0]],
                                                    vecs[i].wdata, vecs[i].be);
        end
        check("rw_mem_unchanged", sram_mem[16], 16'hA5A5);
        check("be0_mem_unchanged", sram_mem[32], 16'hAB11);

        // Master drops the read after T1: the cycle and its acknowledge still happen.
        do_txn(0, OP_RD, 20'h0005A, 2'b11, 16'h0000, 1, rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);
        check_txn("drop_rd", 0, OP_RD, 16'hBE34, rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);

        // Reset during the second write-pulse cycle.
        address = 20'h00030; byteenable = 2'b11; writedata = 16'h4321; write0 = 1'b1;
        repeat (4) @(negedge clock);
        check("midwr_we_low", we0, 0);
        #1 reset_n = 1'b0;
        #1;
        check("midwr_we_released", we0, 1);
        check("midwr_bus_z", bus0, 16'hFFFF);
        check("midwr_ce_released", ce0, 1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check($sformatf("midwr_no_ack%0d", c), {wait0, rdy0}, 2'b10);
        end
        write0 = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_txn(0, OP_RD, 20'h0005A, 2'b11, 16'h0000, -1, rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);
        check_txn("post_rst_rd", 0, OP_RD, 16'hBE34, rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);

        for (int i = 0; i < 40; i++) begin
            dut = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 2));
            a   = 20'h00100 + 20'($urandom_range(0, 15));
            be  = 2'($urandom_range(0, 3));
            wd  = 16'($urandom);
            if (wd == 16'hFFFF) wd = 16'hFFFE;
            do_txn(dut, op, a, be, wd, -1, rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);
            check_txn($sformatf("rnd%0d", i), dut, op, ref_mem[a[9:0]],
                      rdata, ack, wl_cnt, rdy_m, oe_m, we_m, drv_m);
            if (op == OP_WR) ref_mem[a[9:0]] = merge(ref_mem[a[9:0]], wd, be);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end
        for (int i = 256; i < 272; i++)
            check($sformatf("final_mem_%0h", i), sram_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
